bitmap_addr_gen: RTL and testbench

BITMAP_ADDR_GEN -- requirements
Module: bitmap_addr_gen

---
 rtl/bitmap_addr_pkg.sv | 12 +
 rtl/bitmap_addr_gen_if.sv | 48 ++++
 rtl/bitmap_addr_gen_axis_counter.sv | 48 ++++
 rtl/bitmap_addr_gen.sv | 75 +++++++
 tb/tb_bitmap_addr_gen.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/bitmap_addr_pkg.sv
// bitmap_addr_pkg: default coordinate widths and DRAM word-address width derivation.
package bitmap_addr_pkg;

    localparam int XW_DEF   = 8;
    localparam int YW_DEF   = 8;
    localparam int PIXW_DEF = 2;

    function automatic int calc_aw(input int xw, input int yw, input int pixw);
        return xw + yw - pixw;
    endfunction

endpackage

// File: rtl/bitmap_addr_gen_if.sv
// bitmap_addr_gen_if: control and address bus of bitmap_addr_gen; clip exists only with BITMAP_CLIP_EN.
interface bitmap_addr_gen_if
    import bitmap_addr_pkg::*;
#(
    parameter int XW   = XW_DEF,
    parameter int YW   = YW_DEF,
    parameter int PIXW = PIXW_DEF
);

    localparam int AW = calc_aw(XW, YW, PIXW);
    // a zero-width pixel select is carried as a single constant bit
    localparam int PW = (PIXW > 0) ? PIXW : 1;

    logic          x_load;
    logic          y_load;
    logic          x_dec;
    logic          y_dec;
    logic          x_step_en;
    logic          y_step_en;
    logic          access;
    logic          bitmap_mode;
    logic [7:0]    din;
    logic [15:0]   cpu_addr;
    logic [AW-1:0] dram_addr;
    logic [PW-1:0] pix_sel;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
`ifdef BITMAP_CLIP_EN
    logic          clip;
`endif

    modport master (
        output x_load, y_load, x_dec, y_dec, x_step_en, y_step_en, access, bitmap_mode, din, cpu_addr,
        input  dram_addr, pix_sel, x_out, y_out
`ifdef BITMAP_CLIP_EN
        , clip
`endif
    );

    modport slave (
        input  x_load, y_load, x_dec, y_dec, x_step_en, y_step_en, access, bitmap_mode, din, cpu_addr,
        output dram_addr, pix_sel, x_out, y_out
`ifdef BITMAP_CLIP_EN
        , clip
`endif
    );

endinterface

// File: rtl/bitmap_addr_gen_axis_counter.sv
// axis_counter: loadable up/down coordinate counter, wrapping or saturating; sticky flag port with BITMAP_CLIP_EN.
module axis_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         step,
    input  logic         dec,
`ifdef BITMAP_CLIP_EN
    output logic         flag,
`endif
    output logic [W-1:0] val
);

    logic [W-1:0] val_q, val_d;
    logic         at_lim, sat_hit;

    // adding all-ones is the modulo-2^W decrement
    always_comb begin
        at_lim  = dec ? (val_q == '0) : (val_q == '1);
        sat_hit = SAT && step && !load && at_lim;
        val_d   = load ? din : (step && !sat_hit) ? val_q + (dec ? {W{1'b1}} : W'(1)) : val_q;
    end

    always_ff @(posedge clk) begin
        if (rst) val_q <= '0;
        else     val_q <= val_d;
    end

    assign val = val_q;

`ifdef BITMAP_CLIP_EN
    logic flag_q, flag_d;

    always_comb flag_d = load ? 1'b0 : sat_hit ? 1'b1 : flag_q;

    always_ff @(posedge clk) begin
        if (rst) flag_q <= 1'b0;
        else     flag_q <= flag_d;
    end

    assign flag = flag_q;
`endif

endmodule

// File: rtl/bitmap_addr_gen.sv
// bitmap_addr_gen: X/Y bitmap coordinate counters and DRAM word-address mux.
// Define BITMAP_CLIP_EN for saturating axes and the sticky clip output.
module bitmap_addr_gen
    import bitmap_addr_pkg::*;
#(
    parameter int XW   = XW_DEF,
    parameter int YW   = YW_DEF,
    parameter int PIXW = PIXW_DEF
) (
    input  logic             clk,
    input  logic             RESET,
    bitmap_addr_gen_if.slave bus
);

    localparam int AW = calc_aw(XW, YW, PIXW);
`ifdef BITMAP_CLIP_EN
    localparam bit SAT = 1'b1;
    logic x_flag, y_flag;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [XW-1:0] x_val, x;
    logic [YW-1:0] y_val, y;
    logic [16:0]   cpu_ext;
    logic          unused_bits;

    axis_counter #(.W(XW), .SAT(SAT)) u_x (
        .clk  (clk),
        .rst  (RESET),
        .load (bus.x_load),
        .din  (bus.din[XW-1:0]),
        .step (bus.access & bus.x_step_en),
        .dec  (bus.x_dec),
`ifdef BITMAP_CLIP_EN
        .flag (x_flag),
`endif
        .val  (x_val)
    );

    axis_counter #(.W(YW), .SAT(SAT)) u_y (
        .clk  (clk),
        .rst  (RESET),
        .load (bus.y_load),
        .din  (bus.din[YW-1:0]),
        .step (bus.access & bus.y_step_en),
        .dec  (bus.y_dec),
`ifdef BITMAP_CLIP_EN
        .flag (y_flag),
`endif
        .val  (y_val)
    );

    // coordinates read as zero for the whole reset assertion, not just after the edge
    always_comb begin
        x             = RESET ? '0 : x_val;
        y             = RESET ? '0 : y_val;
        cpu_ext       = {1'b0, bus.cpu_addr};
        bus.x_out     = x;
        bus.y_out     = y;
        bus.dram_addr = bus.bitmap_mode ? {y, x[XW-1:PIXW]} : cpu_ext[AW:1];
        unused_bits   = ^{cpu_ext, bus.din};
    end

    if (PIXW > 0) begin : g_pix
        assign bus.pix_sel = x[PIXW-1:0];
    end else begin : g_nopix
        assign bus.pix_sel = 1'b0;
    end

`ifdef BITMAP_CLIP_EN
    assign bus.clip = x_flag | y_flag;
`endif

endmodule

// File: tb/tb_bitmap_addr_gen.sv
// tb_bitmap_addr_gen: scoreboard bench driving a default and a 6/5/1 build with shared stimulus.
module tb_bitmap_addr_gen;
    import bitmap_addr_pkg::*;

    typedef struct {
        string name;
        int    ax, ay, ad, ap, ac;
        int    sx, sy, sd, sp, sc;
    } exp_t;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    bitmap_addr_gen_if a ();
    bitmap_addr_gen_if #(.XW(6), .YW(5), .PIXW(1)) s ();

    bitmap_addr_gen dut_a (.clk(clk), .RESET(RESET), .bus(a.slave));
    bitmap_addr_gen #(.XW(6), .YW(5), .PIXW(1)) dut_s (.clk(clk), .RESET(RESET), .bus(s.slave));

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   ax_m = 0, ay_m = 0, afx = 0, afy = 0;
    int   sx_m = 0, sy_m = 0, sfx = 0, sfy = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    // next coordinate from the rules: reset, then load, then step (wrap or clamp)
    function automatic int nxt(input int v, input int w, input bit r, input bit ld, input int d,
                               input bit st, input bit dec, inout int f);
        int mx;
        mx = (1 << w) - 1;
        if (r) begin f = 0; return 0; end
        if (ld) begin f = 0; return d & mx; end
        if (!st) return v;
`ifdef BITMAP_CLIP_EN
        if (dec ? (v == 0) : (v == mx)) begin f = 1; return v; end
`endif
        return dec ? (v + mx) & mx : (v + 1) & mx;
    endfunction

    function automatic int addr(input int x, input int y, input int xw, input int pixw,
                                input int aw, input bit mode, input int cpu);
        return mode ? (y << (xw - pixw)) | (x >> pixw) : (cpu >> 1) & ((1 << aw) - 1);
    endfunction

    task automatic cyc(input string n, input bit r, input bit xl, input bit yl, input bit xd,
                       input bit yd, input bit xe, input bit ye, input bit acc, input bit mode,
                       input logic [7:0] d, input logic [15:0] cpu);
        exp_t e;
        @(negedge clk);
        RESET = r;
        a.x_load = xl;      s.x_load = xl;
        a.y_load = yl;      s.y_load = yl;
        a.x_dec = xd;       s.x_dec = xd;
        a.y_dec = yd;       s.y_dec = yd;
        a.x_step_en = xe;   s.x_step_en = xe;
        a.y_step_en = ye;   s.y_step_en = ye;
        a.access = acc;     s.access = acc;
        a.bitmap_mode = mode; s.bitmap_mode = mode;
        a.din = d;          s.din = d;
        a.cpu_addr = cpu;   s.cpu_addr = cpu;
        ax_m = nxt(ax_m, 8, r, xl, int'(d), acc && xe, xd, afx);
        ay_m = nxt(ay_m, 8, r, yl, int'(d), acc && ye, yd, afy);
        sx_m = nxt(sx_m, 6, r, xl, int'(d), acc && xe, xd, sfx);
        sy_m = nxt(sy_m, 5, r, yl, int'(d), acc && ye, yd, sfy);
        e.name = n;
        e.ax = ax_m; e.ay = ay_m; e.ap = ax_m % 4; e.ac = afx | afy;
        e.ad = addr(ax_m, ay_m, 8, 2, 14, mode, int'(cpu));
        e.sx = sx_m; e.sy = sy_m; e.sp = sx_m % 2; e.sc = sfx | sfy;
        e.sd = addr(sx_m, sy_m, 6, 1, 10, mode, int'(cpu));
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".x"}, 32'(a.x_out), e.ax);
                chk({e.name, ".y"}, 32'(a.y_out), e.ay);
                chk({e.name, ".addr"}, 32'(a.dram_addr), e.ad);
                chk({e.name, ".pix"}, 32'(a.pix_sel), e.ap);
                chk({e.name, ".s_x"}, 32'(s.x_out), e.sx);
                chk({e.name, ".s_y"}, 32'(s.y_out), e.sy);
                chk({e.name, ".s_addr"}, 32'(s.dram_addr), e.sd);
                chk({e.name, ".s_pix"}, 32'(s.pix_sel), e.sp);
`ifdef BITMAP_CLIP_EN
                chk({e.name, ".clip"}, 32'(a.clip), e.ac);
                chk({e.name, ".s_clip"}, 32'(s.clip), e.sc);
`endif
            end
        end
    end

    initial begin
        bit r, xl, yl, xd, yd, xe, ye, acc, mode;
        logic [7:0] d;
        RESET = 1'b1;
        a.x_load = 0; a.y_load = 0; a.x_dec = 0; a.y_dec = 0; a.x_step_en = 0; a.y_step_en = 0;
        a.access = 0; a.bitmap_mode = 0; a.din = 0; a.cpu_addr = 0;
        s.x_load = 0; s.y_load = 0; s.x_dec = 0; s.y_dec = 0; s.x_step_en = 0; s.y_step_en = 0;
        s.access = 0; s.bitmap_mode = 0; s.din = 0; s.cpu_addr = 0;
        cyc("init", 1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 16'h0000);
        cyc("ld37", 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h37, 16'h0000);
        cyc("rst",  1, 0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 16'h0000);
        #1;
        chk("rst_comb.x", 32'(a.x_out), 0);
        cyc("ldx5a", 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h5A, 16'h0000);
        cyc("ldy12", 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h12, 16'h0000);
        cyc("ldxff", 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'hFF, 16'h0000);
        cyc("xwrap", 0, 0, 0, 0, 0, 1, 0, 1, 1, 8'h00, 16'h0000);
        cyc("ldpri", 0, 1, 0, 0, 0, 1, 0, 1, 1, 8'h10, 16'h0000);
        cyc("cpu",   0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 16'h9ABC);
        cyc("ldy0",  0, 0, 1, 0, 0, 0, 0, 0, 1, 8'h00, 16'h0000);
        cyc("ywrap", 0, 0, 0, 0, 1, 0, 1, 1, 1, 8'h00, 16'h0000);
        cyc("both",  0, 0, 0, 1, 0, 1, 1, 1, 1, 8'h00, 16'h0000);
        for (int i = 0; i < 400; i++) begin
            r    = ($urandom_range(0, 39) == 0);
            xl   = ($urandom_range(0, 7) == 0);
            yl   = ($urandom_range(0, 7) == 0);
            xd   = 1'($urandom);
            yd   = 1'($urandom);
            xe   = ($urandom_range(0, 3) != 0);
            ye   = ($urandom_range(0, 3) != 0);
            acc  = 1'($urandom);
            mode = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            cyc("rand", r, xl, yl, xd, yd, xe, ye, acc, mode, d, 16'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        chk("q_drain", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
